// File: rtl/nios_multi_timer_pkg.sv
// Shared constants for the multi-channel interval timer: register offsets and bit positions.
package nios_multi_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAPSHOT = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_COMPARE  = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

    // Word address is {channel, reg[2:0]}.
    function automatic int addr_w(input int num_ch);
        return 3 + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/nios_multi_timer_if.sv
// Avalon-MM slave bus plus interrupt outputs of the multi-channel timer.
interface nios_multi_timer_if #(
    parameter int NUM_CH = 4
);
    localparam int ADDR_W = 3 + $clog2(NUM_CH);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] ch_irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq, ch_irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq, ch_irq
    );
endinterface

// File: rtl/nios_multi_timer_ch.sv
// One timer channel: register bank, prescaler, down-counter, timeout flag and optional PWM.
// PWM output present only when NIOS_MULTI_TIMER_PWM_EN is defined.
module nios_multi_timer_ch
    import nios_multi_timer_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int PRE_W          = 16,
    parameter int DEFAULT_PERIOD = 49999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_i,
    input  logic [2:0]  reg_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
`ifdef NIOS_MULTI_TIMER_PWM_EN
    ,
    output logic        pwm_o
`endif
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pcount_q, pcount_d;
    logic             run_q, run_d;
    logic             to_q, to_d;
    logic             cont_q, cont_d;
    logic             ito_q, ito_d;
    logic             reload_q, reload_d;

    logic st_wr, ctl_wr, per_wr, snap_wr, pre_wr, cmp_wr;
    logic start, stop, tick, timeout;

    always_comb begin
        st_wr   = wr_i && (reg_i == REG_STATUS);
        ctl_wr  = wr_i && (reg_i == REG_CONTROL);
        per_wr  = wr_i && (reg_i == REG_PERIOD);
        snap_wr = wr_i && (reg_i == REG_SNAPSHOT);
        pre_wr  = wr_i && (reg_i == REG_PRESCALE);
        cmp_wr  = wr_i && (reg_i == REG_COMPARE);
        start   = ctl_wr && wdata_i[CTL_START];
        stop    = ctl_wr && wdata_i[CTL_STOP];
        tick    = run_q && (pcount_q == pre_q);
        timeout = tick && (cnt_q == '0);
    end

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        snap_d   = snap_q;
        cmp_d    = cmp_q;
        pre_d    = pre_q;
        pcount_d = pcount_q;
        run_d    = run_q;
        to_d     = to_q;
        cont_d   = cont_q;
        ito_d    = ito_q;
        reload_d = per_wr;

        if (tick) begin
            cnt_d = timeout ? period_q : cnt_q - CNT_W'(1);
        end
        if (run_q) begin
            pcount_d = tick ? '0 : pcount_q + PRE_W'(1);
        end
        if (timeout) begin
            run_d = cont_q;
        end

        // A PERIOD write reloads one cycle later, after period_q holds the new value.
        if (reload_q) begin
            cnt_d    = period_q;
            pcount_d = '0;
        end

        if (stop || reload_q) begin
            run_d = 1'b0;
        end
        if (start) begin
            run_d    = 1'b1;
            pcount_d = '0;
        end

        if (st_wr) begin
            to_d = 1'b0;
        end
        if (timeout) begin
            to_d = 1'b1;
        end

        if (ctl_wr) begin
            cont_d = wdata_i[CTL_CONT];
            ito_d  = wdata_i[CTL_ITO];
        end
        if (per_wr)  period_d = wdata_i[CNT_W-1:0];
        if (snap_wr) snap_d   = cnt_q;
        if (pre_wr)  pre_d    = wdata_i[PRE_W-1:0];
        if (cmp_wr)  cmp_d    = wdata_i[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= CNT_W'(DEFAULT_PERIOD);
            period_q <= CNT_W'(DEFAULT_PERIOD);
            snap_q   <= '0;
            cmp_q    <= '0;
            pre_q    <= '0;
            pcount_q <= '0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            cont_q   <= 1'b0;
            ito_q    <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            cmp_q    <= cmp_d;
            pre_q    <= pre_d;
            pcount_q <= pcount_d;
            run_q    <= run_d;
            to_q     <= to_d;
            cont_q   <= cont_d;
            ito_q    <= ito_d;
            reload_q <= reload_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            REG_STATUS: begin
                rdata_o[ST_TO]  = to_q;
                rdata_o[ST_RUN] = run_q;
            end
            REG_CONTROL: begin
                rdata_o[CTL_ITO]  = ito_q;
                rdata_o[CTL_CONT] = cont_q;
            end
            REG_PERIOD:   rdata_o = 32'(period_q);
            REG_SNAPSHOT: rdata_o = 32'(snap_q);
            REG_PRESCALE: rdata_o = 32'(pre_q);
            REG_COMPARE:  rdata_o = 32'(cmp_q);
            default:      rdata_o = '0;
        endcase
    end

    assign irq_o = to_q && ito_q;

`ifdef NIOS_MULTI_TIMER_PWM_EN
    logic pwm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= run_q && (cnt_q < cmp_q);
        end
    end

    assign pwm_o = pwm_q;
`endif

endmodule

// File: rtl/nios_multi_timer.sv
// Multi-channel interval timer behind one Avalon-MM slave: address decode, read mux, irq OR.
// Optional per-channel PWM outputs when NIOS_MULTI_TIMER_PWM_EN is defined.
module nios_multi_timer
    import nios_multi_timer_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int PRE_W          = 16,
    parameter int DEFAULT_PERIOD = 49999
) (
    input  logic               clk,
    input  logic               reset,
    nios_multi_timer_if.slave  bus
`ifdef NIOS_MULTI_TIMER_PWM_EN
    ,
    output logic [NUM_CH-1:0]  pwm_out
`endif
);

    localparam int ADDR_W = addr_w(NUM_CH);

    logic              wr;
    logic [ADDR_W-1:0] ch_sel;
    logic [2:0]        reg_sel;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] ch_irq_w;
    logic [31:0]       rdata_q, rdata_d;

    assign wr      = bus.chipselect && !bus.write_n;
    assign ch_sel  = bus.address >> 3;
    assign reg_sel = bus.address[2:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nios_multi_timer_ch #(
            .CNT_W          (CNT_W),
            .PRE_W          (PRE_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr_i    (wr && (ch_sel == ADDR_W'(i))),
            .reg_i   (reg_sel),
            .wdata_i (bus.writedata),
            .rdata_o (ch_rdata[i]),
            .irq_o   (ch_irq_w[i])
`ifdef NIOS_MULTI_TIMER_PWM_EN
            ,
            .pwm_o   (pwm_out[i])
`endif
        );
    end

    // Channel numbers at or above NUM_CH fall through and read zero.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                rdata_d = ch_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign bus.ch_irq   = ch_irq_w;
    assign bus.irq      = |ch_irq_w;

endmodule
